alu_issue_stage: RTL and testbench

- Registered ID/EX issue stage for the RV32 core.
- Decodes a 32-bit instruction, selects ALU operands from register data, PC or immediate, and drives the ALU's operation code and operands from a pipeline register.
- Sits between register-file read and the combinational ALU. It is the producer side of the ALU's ALUop/op1/op2 interface.
- Uses valid/ready handshakes on both sides, plus flush and an issue counter.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_op_decode.sv | 147 ++++++++++++++
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 tb/tb_alu_issue_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, RV32 opcodes, immediate widths and
// the operand-select encodings used between decode and the issue register.
package alu_pkg;

    localparam logic [3:0] ADD_OP = 4'b0000;
    localparam logic [3:0] SUB_OP = 4'b0001;
    localparam logic [3:0] AND_OP = 4'b0010;
    localparam logic [3:0] OR_OP  = 4'b0011;
    localparam logic [3:0] XOR_OP = 4'b0100;
    localparam logic [3:0] SLL_OP = 4'b0101;
    localparam logic [3:0] SRL_OP = 4'b0110;
    localparam logic [3:0] SRA_OP = 4'b0111;
    // The ALU treats this code as an unsigned compare.
    localparam logic [3:0] SLT_OP = 4'b1000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int I_IMM_W = 12;
    localparam int S_IMM_W = 12;
    localparam int U_IMM_W = 20;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2,
        OP2_ZERO = 2'd3
    } op2_sel_e;

    function automatic logic [31:0] sext_i(input logic [I_IMM_W-1:0] v);
        return {{(32-I_IMM_W){v[I_IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32 decode into ALU operation, operand selects, immediate,
// destination write enable and the illegal/unsupported flag.
module alu_op_decode
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [3:0]      alu_op_o,
    output op1_sel_e        op1_sel_o,
    output op2_sel_e        op2_sel_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            illegal_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
    logic [31:0] shamt32;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7    = instr_i[31:25];
    assign rd_addr_o = instr_i[11:7];
    assign shamt32   = {{(32-SHAMT_W){1'b0}}, instr_i[24:20]};

    always_comb begin
        alu_op_o  = ADD_OP;
        op1_sel_o = OP1_RS1;
        op2_sel_o = OP2_RS2;
        imm32     = '0;
        rd_we_o   = 1'b0;
        illegal_o = 1'b0;

        case (opcode)
            OPC_OP: begin
                rd_we_o = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE)     alu_op_o = ADD_OP;
                        else if (funct7 == F7_ALT) alu_op_o = SUB_OP;
                        else                       illegal_o = 1'b1;
                    end
                    3'b001: begin
                        alu_op_o  = SLL_OP;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    3'b011: begin
                        alu_op_o  = SLT_OP;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    3'b100: begin
                        alu_op_o  = XOR_OP;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE)     alu_op_o = SRL_OP;
                        else if (funct7 == F7_ALT) alu_op_o = SRA_OP;
                        else                       illegal_o = 1'b1;
                    end
                    3'b110: begin
                        alu_op_o  = OR_OP;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    3'b111: begin
                        alu_op_o  = AND_OP;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    // Signed SLT has no ALU encoding.
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                rd_we_o   = 1'b1;
                op2_sel_o = OP2_IMM;
                imm32     = sext_i(instr_i[31:20]);
                case (funct3)
                    3'b000: alu_op_o = ADD_OP;
                    3'b011: alu_op_o = SLT_OP;
                    3'b100: alu_op_o = XOR_OP;
                    3'b110: alu_op_o = OR_OP;
                    3'b111: alu_op_o = AND_OP;
                    3'b001: begin
                        alu_op_o  = SLL_OP;
                        imm32     = shamt32;
                        illegal_o = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        imm32 = shamt32;
                        if (funct7 == F7_BASE)     alu_op_o = SRL_OP;
                        else if (funct7 == F7_ALT) alu_op_o = SRA_OP;
                        else                       illegal_o = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_LUI: begin
                rd_we_o   = 1'b1;
                op1_sel_o = OP1_ZERO;
                op2_sel_o = OP2_IMM;
                imm32     = {instr_i[31:32-U_IMM_W], 12'b0};
            end
            OPC_AUIPC: begin
                rd_we_o   = 1'b1;
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_IMM;
                imm32     = {instr_i[31:32-U_IMM_W], 12'b0};
            end
            OPC_LOAD: begin
                rd_we_o   = 1'b1;
                op2_sel_o = OP2_IMM;
                imm32     = sext_i(instr_i[31:20]);
            end
            OPC_STORE: begin
                op2_sel_o = OP2_IMM;
                imm32     = sext_i({instr_i[31:25], instr_i[11:7]});
            end
            OPC_BRANCH: begin
                alu_op_o = SUB_OP;
            end
            OPC_JAL, OPC_JALR: begin
                rd_we_o   = 1'b1;
                op1_sel_o = OP1_PC;
                op2_sel_o = OP2_FOUR;
            end
            default: illegal_o = 1'b1;
        endcase

        // Illegal ops still issue, but as a harmless 0 + 0 with no writeback.
        if (illegal_o) begin
            alu_op_o  = ADD_OP;
            op1_sel_o = OP1_ZERO;
            op2_sel_o = OP2_ZERO;
            imm32     = '0;
            rd_we_o   = 1'b0;
        end
        if (instr_i[11:7] == 5'd0) begin
            rd_we_o = 1'b0;
        end
    end

    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes one instruction, muxes ALU operands and holds
// them for the ALU behind a single-entry valid/ready register with flush.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALUop,
    output logic [XLEN-1:0]  op1,
    output logic [XLEN-1:0]  op2,
    output logic [4:0]       rd_addr,
    output logic             rd_we,
    output logic             illegal,
    output logic [CNT_W-1:0] issue_cnt
);

    logic [3:0]      dec_alu_op;
    op1_sel_e        dec_op1_sel;
    op2_sel_e        dec_op2_sel;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rd_addr;
    logic            dec_rd_we;
    logic            dec_illegal;
    logic [XLEN-1:0] op1_mux;
    logic [XLEN-1:0] op2_mux;

    alu_op_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (instr),
        .alu_op_o  (dec_alu_op),
        .op1_sel_o (dec_op1_sel),
        .op2_sel_o (dec_op2_sel),
        .imm_o     (dec_imm),
        .rd_addr_o (dec_rd_addr),
        .rd_we_o   (dec_rd_we),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        case (dec_op1_sel)
            OP1_RS1: op1_mux = rs1_data;
            OP1_PC:  op1_mux = pc;
            default: op1_mux = '0;
        endcase
        case (dec_op2_sel)
            OP2_RS2:  op2_mux = rs2_data;
            OP2_IMM:  op2_mux = dec_imm;
            OP2_FOUR: op2_mux = XLEN'(4);
            default:  op2_mux = '0;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The upstream side may load whenever the register is empty or is being
    // drained this cycle (one entry, no skid); the held op stays stable while
    // out_valid && !out_ready. flush_i overrides both load and consume.
    logic             out_valid_q, out_valid_d;
    logic [3:0]       alu_op_q,    alu_op_d;
    logic [XLEN-1:0]  op1_q,       op1_d;
    logic [XLEN-1:0]  op2_q,       op2_d;
    logic [4:0]       rd_addr_q,   rd_addr_d;
    logic             rd_we_q,     rd_we_d;
    logic             illegal_q,   illegal_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic             load;
    logic             consume;

    assign in_ready = !out_valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush_i;
    assign consume  = out_valid_q && out_ready && !flush_i;

    always_comb begin
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        rd_addr_d   = rd_addr_q;
        rd_we_d     = rd_we_q;
        illegal_d   = illegal_q;
        issue_cnt_d = issue_cnt_q + CNT_W'(consume);

        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = 1'b1;
            alu_op_d    = dec_alu_op;
            op1_d       = op1_mux;
            op2_d       = op2_mux;
            rd_addr_d   = dec_rd_addr;
            rd_we_d     = dec_rd_we;
            illegal_d   = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_op_q    <= ADD_OP;
            op1_q       <= '0;
            op2_q       <= '0;
            rd_addr_q   <= '0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            rd_addr_q   <= rd_addr_d;
            rd_we_q     <= rd_we_d;
            illegal_q   <= illegal_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUop     = alu_op_q;
    assign op1       = op1_q;
    assign op2       = op2_q;
    assign rd_addr   = rd_addr_q;
    assign rd_we     = rd_we_q;
    assign illegal   = illegal_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, backpressure, flush,
// asynchronous reset and a 4-bit issue counter wrap.
module tb_alu_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int EXP_W = 1 + 1 + 5 + 4 + 32 + 32;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ALUop;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic             illegal;
    logic [CNT_W-1:0] issue_cnt;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (flush_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUop     (ALUop),
        .op1       (op1),
        .op2       (op2),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .illegal   (illegal),
        .issue_cnt (issue_cnt)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking / scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    int consumed = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] exp_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_op(input logic ill, input logic we, input logic [4:0] rd,
                             input logic [3:0] aop, input logic [31:0] o1, input logic [31:0] o2);
        exp_q.push_back({ill, we, rd, aop, o1, o2});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush_i) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_e = exp_q.pop_front();
                check($sformatf("op%0d_illegal", consumed), 32'(illegal), 32'(exp_e[74]));
                check($sformatf("op%0d_rd_we",   consumed), 32'(rd_we),   32'(exp_e[73]));
                check($sformatf("op%0d_rd_addr", consumed), 32'(rd_addr), 32'(exp_e[72:68]));
                check($sformatf("op%0d_aluop",   consumed), 32'(ALUop),   32'(exp_e[67:64]));
                check($sformatf("op%0d_op1",     consumed), op1,          exp_e[63:32]);
                check($sformatf("op%0d_op2",     consumed), op2,          exp_e[31:0]);
            end
            consumed++;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
        logic hs;
        instr    = i;
        pc       = p;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        hs       = 1'b0;
        for (int n = 0; n < 20 && !hs; n++) begin
            @(negedge clk);
            hs = in_ready;
            tick();
        end
        in_valid = 1'b0;
        check("send_hs", 32'(hs), 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] instr, pc, rs1, rs2;
        logic        ill, we;
        logic [4:0]  rd;
        logic [3:0]  aop;
        logic [31:0] o1, o2;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'h002081B3, 32'h100,  32'h5,        32'h7,  1'b0, 1'b1, 5'd3,  4'h0, 32'h5,        32'h7};        // ADD
        vecs[1]  = '{32'h40335293, 32'h104,  32'h80000000, 32'h0,  1'b0, 1'b1, 5'd5,  4'h7, 32'h80000000, 32'h3};        // SRAI
        vecs[2]  = '{32'h402081B3, 32'h108,  32'h5,        32'h7,  1'b0, 1'b1, 5'd3,  4'h1, 32'h5,        32'h7};        // SUB
        vecs[3]  = '{32'h123450B7, 32'h10C,  32'hDEADBEEF, 32'h0,  1'b0, 1'b1, 5'd1,  4'h0, 32'h0,        32'h12345000}; // LUI
        vecs[4]  = '{32'h0020A1B3, 32'h110,  32'h5,        32'h7,  1'b1, 1'b0, 5'd3,  4'h0, 32'h0,        32'h0};        // SLT signed
        vecs[5]  = '{32'h00001217, 32'h1000, 32'h0,        32'h0,  1'b0, 1'b1, 5'd4,  4'h0, 32'h1000,     32'h1000};     // AUIPC
        vecs[6]  = '{32'hFFF10093, 32'h114,  32'hA,        32'h0,  1'b0, 1'b1, 5'd1,  4'h0, 32'hA,        32'hFFFFFFFF}; // ADDI -1
        vecs[7]  = '{32'hFE20AE23, 32'h118,  32'h100,      32'h55, 1'b0, 1'b0, 5'd28, 4'h0, 32'h100,      32'hFFFFFFFC}; // SW -4
        vecs[8]  = '{32'h00208063, 32'h11C,  32'h9,        32'h9,  1'b0, 1'b0, 5'd0,  4'h1, 32'h9,        32'h9};        // BEQ
        vecs[9]  = '{32'h000000EF, 32'h2000, 32'h0,        32'h0,  1'b0, 1'b1, 5'd1,  4'h0, 32'h2000,     32'h4};        // JAL
        vecs[10] = '{32'h00208033, 32'h120,  32'h3,        32'h4,  1'b0, 1'b0, 5'd0,  4'h0, 32'h3,        32'h4};        // ADD x0
        vecs[11] = '{32'h000001FF, 32'h124,  32'h1,        32'h2,  1'b1, 1'b0, 5'd3,  4'h0, 32'h0,        32'h0};        // bad opcode
        vecs[12] = '{32'h0010B293, 32'h128,  32'h6,        32'h0,  1'b0, 1'b1, 5'd5,  4'h8, 32'h6,        32'h1};        // SLTIU
        vecs[13] = '{32'h0220E1B3, 32'h12C,  32'h1,        32'h2,  1'b1, 1'b0, 5'd3,  4'h0, 32'h0,        32'h0};        // OR bad funct7
        vecs[14] = '{32'h0020C1B3, 32'h130,  32'hF0,       32'h0F, 1'b0, 1'b1, 5'd3,  4'h4, 32'hF0,       32'h0F};       // XOR
        vecs[15] = '{32'h0020D1B3, 32'h134,  32'h80,       32'h2,  1'b0, 1'b1, 5'd3,  4'h6, 32'h80,       32'h2};        // SRL
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_aluop",     32'(ALUop),     32'd0);
        check("rst_op1",       op1,            32'd0);
        check("rst_op2",       op2,            32'd0);
        check("rst_rd_addr",   32'(rd_addr),   32'd0);
        check("rst_rd_we",     32'(rd_we),     32'd0);
        check("rst_illegal",   32'(illegal),   32'd0);
        check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Streamed decode table; 16 consumed ops wrap the 4-bit counter.
        out_ready = 1'b1;
        foreach (vecs[k]) begin
            expect_op(vecs[k].ill, vecs[k].we, vecs[k].rd, vecs[k].aop, vecs[k].o1, vecs[k].o2);
            send(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        check("stream_drained",  32'(out_valid), 32'd0);
        check("stream_consumed", 32'(consumed),  32'd16);
        check("cnt_wrap",        32'(issue_cnt), 32'd0);

        // Backpressure: held op stays put, next op waits.
        tick();
        out_ready = 1'b0;
        expect_op(1'b0, 1'b1, 5'd3, 4'h0, 32'h1, 32'h2);
        send(32'h002081B3, 32'h200, 32'h1, 32'h2);
        expect_op(1'b0, 1'b1, 5'd3, 4'h1, 32'h9, 32'h4);
        instr    = 32'h402081B3;
        rs1_data = 32'h9;
        rs2_data = 32'h4;
        in_valid = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("bp%0d_in_ready", n),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d_out_valid", n), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_aluop", n),     32'(ALUop),     32'd0);
            check($sformatf("bp%0d_op1", n),       op1,            32'h1);
            check($sformatf("bp%0d_op2", n),       op2,            32'h2);
            check($sformatf("bp%0d_cnt", n),       32'(issue_cnt), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_cnt_after_release", 32'(issue_cnt), 32'd1);
        check("bp_next_loaded",       32'(ALUop),     32'h1);
        tick();
        @(negedge clk);
        check("bp_cnt_final",   32'(issue_cnt), 32'd2);
        check("bp_valid_final", 32'(out_valid), 32'd0);

        // Flush with a held op being consumed and a new op offered.
        tick();
        out_ready = 1'b0;
        send(32'h002081B3, 32'h300, 32'h11, 32'h22);
        instr     = 32'h402081B3;
        rs1_data  = 32'h33;
        rs2_data  = 32'h44;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush_i   = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        tick();
        flush_i  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_cnt",       32'(issue_cnt), 32'd2);
        tick();
        @(negedge clk);
        check("flush_stays_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a held op.
        tick();
        out_ready = 1'b0;
        send(32'h002081B3, 32'h400, 32'h5, 32'h7);
        @(negedge clk);
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_op1",       op1,            32'd0);
        check("arst_op2",       op2,            32'd0);
        check("arst_rd_addr",   32'(rd_addr),   32'd0);
        check("arst_rd_we",     32'(rd_we),     32'd0);
        check("arst_cnt",       32'(issue_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
